// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the EX stage and the RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            select;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  flush;
  logic                  busy;
  logic                  stall;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;

  modport master (
    output start, select, operand_a, operand_b, flush,
    input  busy, stall, result, result_valid
  );

  modport slave (
    input  start, select, operand_a, operand_b, flush,
    output busy, stall, result, result_valid
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: registered multiplier plus radix-2 restoring divider,
// stalling the pipeline until a one-cycle result_valid pulse.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  muldiv_sequencer_if.slave io
);
  localparam int W        = DATA_WIDTH;
  localparam int CMAX     = (DATA_WIDTH > MUL_CYCLES) ? DATA_WIDTH : MUL_CYCLES;
  localparam int CW       = $clog2(CMAX + 1);
  localparam int MUL_LAST = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MUL_WAIT = 3'd1;
  localparam logic [2:0] DIV_RUN  = 3'd2;
  localparam logic [2:0] DIV_FIX  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          busy, result_valid;
  logic [W-1:0]  result;
  logic [1:0]    sel;
  logic [W-1:0]  opa, opb;
  logic [W-1:0]  quo, rem, dvs;
  logic          neg_q, neg_r;

  logic          idle_like, div_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0]  a_mag, b_mag;
  logic [1:0]    m_sel;
  logic [W-1:0]  m_a, m_b;
  logic          a_sgn, b_sgn;
  logic [2*W-1:0] ext_a, ext_b, product;
  logic [W-1:0]  mul_res;
  logic [W:0]    r_sh, diff;
  logic [W-1:0]  quo_fix, rem_fix;

  always_comb begin
    idle_like  = (state == IDLE) || (state == DONE);
    div_signed = ~io.select[0];
    a_neg      = io.operand_a[W-1];
    b_neg      = io.operand_b[W-1];
    a_mag      = (div_signed & a_neg) ? -io.operand_a : io.operand_a;
    b_mag      = (div_signed & b_neg) ? -io.operand_b : io.operand_b;
    div_zero   = (io.operand_b == '0);
    div_ovf    = div_signed & (io.operand_a == {1'b1, {(W-1){1'b0}}}) & (io.operand_b == '1);

    // With a single multiply cycle the product is taken straight from the live operands at accept.
    m_sel   = (MUL_CYCLES == 1) ? io.select[1:0] : sel;
    m_a     = (MUL_CYCLES == 1) ? io.operand_a   : opa;
    m_b     = (MUL_CYCLES == 1) ? io.operand_b   : opb;
    a_sgn   = (m_sel != 2'b11);
    b_sgn   = (m_sel == 2'b01);
    ext_a   = {{W{a_sgn & m_a[W-1]}}, m_a};
    ext_b   = {{W{b_sgn & m_b[W-1]}}, m_b};
    product = ext_a * ext_b;
    mul_res = (m_sel == 2'b00) ? product[W-1:0] : product[2*W-1:W];

    r_sh    = {rem, quo[W-1]};
    diff    = r_sh - {1'b0, dvs};
    quo_fix = neg_q ? -quo : quo;
    rem_fix = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      sel          <= '0;
      opa          <= '0;
      opb          <= '0;
      quo          <= '0;
      rem          <= '0;
      dvs          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (io.flush) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            state <= IDLE;
            if (io.start) begin
              sel   <= io.select[1:0];
              opa   <= io.operand_a;
              opb   <= io.operand_b;
              cnt   <= '0;
              busy  <= 1'b1;
              quo   <= a_mag;
              rem   <= '0;
              dvs   <= b_mag;
              neg_q <= div_signed & (a_neg ^ b_neg);
              neg_r <= div_signed & a_neg;
              if (!io.select[2]) begin
                if (MUL_CYCLES == 1) begin
                  result       <= mul_res;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= DONE;
                end else begin
                  state <= MUL_WAIT;
                end
              end else if (div_zero) begin
                result       <= io.select[1] ? io.operand_a : '1;
                result_valid <= 1'b1;
                busy         <= 1'b0;
                state        <= DONE;
              end else if (div_ovf) begin
                result       <= io.select[1] ? '0 : io.operand_a;
                result_valid <= 1'b1;
                busy         <= 1'b0;
                state        <= DONE;
              end else begin
                state <= DIV_RUN;
              end
            end
          end
          MUL_WAIT: begin
            if (cnt == CW'(MUL_LAST)) begin
              result       <= mul_res;
              result_valid <= 1'b1;
              busy         <= 1'b0;
              state        <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DIV_RUN: begin
            // Restoring step: a negative trial difference leaves the shifted remainder untouched.
            quo <= {quo[W-2:0], ~diff[W]};
            rem <= diff[W] ? r_sh[W-1:0] : diff[W-1:0];
            if (cnt == CW'(W - 1)) begin
              cnt   <= '0;
              state <= DIV_FIX;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DIV_FIX: begin
            result       <= sel[1] ? rem_fix : quo_fix;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign io.busy         = busy;
  assign io.result       = result;
  assign io.result_valid = result_valid;
  assign io.stall        = (io.start & idle_like & ~io.flush) | (busy & ~result_valid);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: transaction-level reference model compared
// every cycle, plus directed literal checks for the corner cases.
module tb_muldiv_sequencer;
  localparam int MULC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;

  muldiv_sequencer_if #(.DATA_WIDTH(32)) io ();

  muldiv_sequencer #(.DATA_WIDTH(32), .MUL_CYCLES(MULC)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    bit ovf;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ua  = $signed({32'b0, a});
    ub  = $signed({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (s)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
      end
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    if (!s[2]) return MULC;
    if (b == 0) return 1;
    if (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Transaction model: edges remaining until the result pulse of the op in flight.
  bit          m_pend = 1'b0;
  bit          m_valid = 1'b0;
  int          m_rem = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_exp = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 1'b0; m_valid = 1'b0; m_rem = 0; m_res = '0;
    end else begin
      m_valid = 1'b0;
      if (io.flush) begin
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_rem--;
        if (m_rem == 0) begin
          m_pend = 1'b0; m_valid = 1'b1; m_res = m_exp;
        end
      end else if (io.start) begin
        m_exp = ref_res(io.select, io.operand_a, io.operand_b);
        m_rem = ref_lat(io.select, io.operand_a, io.operand_b) - 1;
        if (m_rem == 0) begin
          m_valid = 1'b1; m_res = m_exp;
        end else begin
          m_pend = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("busy", {31'b0, io.busy}, {31'b0, m_pend});
    check("result_valid", {31'b0, io.result_valid}, {31'b0, m_valid});
    check("result", io.result, m_res);
    check("stall", {31'b0, io.stall}, {31'b0, m_pend | (io.start & ~io.flush)});
  end

  task automatic run_op(input string name, input logic [2:0] s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int n;
    bit got;
    @(posedge clk); #2;
    io.start = 1'b1; io.select = s; io.operand_a = a; io.operand_b = b;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin
        io.start = 1'b0; io.operand_a = $urandom; io.operand_b = $urandom;
      end
      if (io.result_valid) got = 1'b1;
    end
    check({name, " result"}, io.result, exp_r);
    check({name, " latency"}, n, exp_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    io.start = 1'b0; io.select = '0; io.operand_a = '0; io.operand_b = '0; io.flush = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, io.busy}, 32'd0);
    check("reset valid", {31'b0, io.result_valid}, 32'd0);
    check("reset result", io.result, 32'd0);
    #1 rst = 1'b0;

    run_op("MUL 7*6", 3'd0, 32'd7, 32'd6, 32'd42, 2);
    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("REM -7%2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("DIVU /0", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REMU /0", 3'd7, 32'h1234, 32'd0, 32'h0000_1234, 1);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 34);

    // Flush mid-division: result must keep 14 and no pulse may follow.
    @(posedge clk); #2;
    io.start = 1'b1; io.select = 3'd4; io.operand_a = 32'd1000; io.operand_b = 32'd3;
    @(posedge clk); #2 io.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 io.flush = 1'b1;
    @(posedge clk); #1;
    check("flush busy", {31'b0, io.busy}, 32'd0);
    check("flush valid", {31'b0, io.result_valid}, 32'd0);
    check("flush result", io.result, 32'd14);
    #1 io.flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (io.result_valid) seen = 1'b1; end
    check("flush no pulse", {31'b0, seen}, 32'd0);

    // Reset during MUL_WAIT.
    @(posedge clk); #2;
    io.start = 1'b1; io.select = 3'd0; io.operand_a = 32'd5; io.operand_b = 32'd9;
    @(posedge clk); #2 io.start = 1'b0; rst = 1'b1;
    #1;
    check("rst mul busy", {31'b0, io.busy}, 32'd0);
    check("rst mul result", io.result, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (io.result_valid) seen = 1'b1; end
    check("rst mul no pulse", {31'b0, seen}, 32'd0);
    run_op("MUL after rst", 3'd0, 32'd5, 32'd9, 32'd45, 2);

    // Reset during DIV_RUN.
    @(posedge clk); #2;
    io.start = 1'b1; io.select = 3'd5; io.operand_a = 32'd1000; io.operand_b = 32'd7;
    @(posedge clk); #2 io.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst div busy", {31'b0, io.busy}, 32'd0);
    check("rst div valid", {31'b0, io.result_valid}, 32'd0);
    check("rst div result", io.result, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (io.result_valid) seen = 1'b1; end
    check("rst div no pulse", {31'b0, seen}, 32'd0);
    run_op("DIVU after rst", 3'd5, 32'd1000, 32'd7, 32'd142, 34);

    // Random traffic: overlapping starts, flushes, operand churn, corner operands.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      io.start  = ($urandom_range(0, 2) == 0);
      io.select = 3'($urandom_range(0, 7));
      io.flush  = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 3))
        0: io.operand_a = 32'h8000_0000;
        1: io.operand_a = 32'($urandom_range(0, 200));
        2: io.operand_a = 32'hFFFF_FFFF - 32'($urandom_range(0, 200));
        default: io.operand_a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: io.operand_b = 32'h0;
        1: io.operand_b = 32'hFFFF_FFFF;
        2: io.operand_b = 32'($urandom_range(1, 50));
        3: io.operand_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
        default: io.operand_b = $urandom;
      endcase
    end
    @(posedge clk); #2 io.start = 1'b0; io.flush = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
